// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port.
// One transaction at a time; data wins ties, but fetch cannot starve beyond MAX_D_STREAK.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_gnt,
  output logic [DW-1:0] i_rdat,
  output logic          i_rv,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdat,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdat,
  output logic          d_rv,
  output logic          d_wv,
  output logic          d_err,
  output logic          m_read_en,
  output logic [AW-1:0] m_read_addr,
  input  logic [DW-1:0] m_read_dat,
  input  logic          m_r_v,
  output logic          m_write_en,
  output logic [AW-1:0] m_write_addr,
  output logic [DW-1:0] m_write_dat,
  input  logic          m_w_v
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [SW-1:0] r_streak;
  logic [TW-1:0] r_tmo;
  logic          r_squash;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdat;
  logic          r_m_read_en;
  logic          r_m_write_en;
  logic [DW-1:0] r_i_rdat;
  logic [DW-1:0] r_d_rdat;
  logic          r_i_rv;
  logic          r_i_err;
  logic          r_d_rv;
  logic          r_d_wv;
  logic          r_d_err;

  logic w_idle;
  logic w_busy;
  logic w_pick_d;
  logic w_pick_i;
  logic w_i_gnt;
  logic w_d_gnt;
  logic w_done;
  logic w_tmo;

  assign w_idle   = (r_state == IDLE);
  assign w_busy   = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_pick_d = d_req && !(i_req && (r_streak == STREAK_MAX));
  assign w_pick_i = !w_pick_d && i_req;
  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign w_i_gnt  = rst_n && w_idle && w_pick_i;
  assign w_d_gnt  = rst_n && w_idle && w_pick_d;
  assign w_done   = w_busy && (r_we ? m_w_v : m_r_v);
  assign w_tmo    = w_busy && !w_done && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_streak     <= '0;
      r_tmo        <= '0;
      r_squash     <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdat       <= '0;
      r_m_read_en  <= 1'b0;
      r_m_write_en <= 1'b0;
      r_i_rdat     <= '0;
      r_d_rdat     <= '0;
      r_i_rv       <= 1'b0;
      r_i_err      <= 1'b0;
      r_d_rv       <= 1'b0;
      r_d_wv       <= 1'b0;
      r_d_err      <= 1'b0;
    end else begin
      r_i_rv  <= 1'b0;
      r_i_err <= 1'b0;
      r_d_rv  <= 1'b0;
      r_d_wv  <= 1'b0;
      r_d_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_req || w_i_gnt) begin
            r_streak <= '0;
          end else if (w_d_gnt && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + SW'(1);
          end
          r_tmo <= '0;
          if (w_d_gnt) begin
            r_state      <= BUSY_D;
            r_we         <= d_we;
            r_addr       <= d_addr;
            r_wdat       <= d_wdat;
            r_m_read_en  <= !d_we;
            r_m_write_en <= d_we;
            r_squash     <= 1'b0;
          end else if (w_i_gnt) begin
            r_state      <= BUSY_I;
            r_we         <= 1'b0;
            r_addr       <= i_addr;
            r_m_read_en  <= 1'b1;
            r_m_write_en <= 1'b0;
            r_squash     <= i_flush;
          end
        end
        BUSY_I, BUSY_D: begin
          if (w_done || w_tmo) begin
            r_state      <= IDLE;
            r_m_read_en  <= 1'b0;
            r_m_write_en <= 1'b0;
            r_tmo        <= '0;
            r_squash     <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
            if ((r_state == BUSY_I) && i_flush) begin
              r_squash <= 1'b1;
            end
          end
          if (w_done) begin
            if (r_state == BUSY_I) begin
              // A flush on the completion cycle itself still squashes.
              if (!(r_squash || i_flush)) begin
                r_i_rv   <= 1'b1;
                r_i_rdat <= m_read_dat;
              end
            end else if (r_we) begin
              r_d_wv <= 1'b1;
            end else begin
              r_d_rv   <= 1'b1;
              r_d_rdat <= m_read_dat;
            end
          end
          if (w_tmo) begin
            if (r_state == BUSY_I) begin
              r_i_err <= 1'b1;
            end else begin
              r_d_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_m_read_en  <= 1'b0;
          r_m_write_en <= 1'b0;
        end
      endcase
    end
  end

  assign i_gnt        = w_i_gnt;
  assign d_gnt        = w_d_gnt;
  assign i_rdat       = r_i_rdat;
  assign i_rv         = r_i_rv;
  assign i_err        = r_i_err;
  assign d_rdat       = r_d_rdat;
  assign d_rv         = r_d_rv;
  assign d_wv         = r_d_wv;
  assign d_err        = r_d_err;
  assign m_read_en    = r_m_read_en;
  assign m_read_addr  = r_addr;
  assign m_write_en   = r_m_write_en;
  assign m_write_addr = r_addr;
  assign m_write_dat  = r_wdat;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions against a behavioural
// memory, a response scoreboard, plus streak, flush and reset sequences.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_D_STREAK = 4;
  localparam int TIMEOUT = 64;

  localparam logic [4:0] P_I_RV  = 5'b10000;
  localparam logic [4:0] P_I_ERR = 5'b01000;
  localparam logic [4:0] P_D_RV  = 5'b00100;
  localparam logic [4:0] P_D_WV  = 5'b00010;
  localparam logic [4:0] P_D_ERR = 5'b00001;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_gnt;
  logic [DW-1:0] i_rdat;
  logic          i_rv;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdat;
  logic          d_gnt;
  logic [DW-1:0] d_rdat;
  logic          d_rv;
  logic          d_wv;
  logic          d_err;
  logic          m_read_en;
  logic [AW-1:0] m_read_addr;
  logic [DW-1:0] m_read_dat;
  logic          m_r_v;
  logic          m_write_en;
  logic [AW-1:0] m_write_addr;
  logic [DW-1:0] m_write_dat;
  logic          m_w_v;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .MAX_D_STREAK(MAX_D_STREAK),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rdat(i_rdat), .i_rv(i_rv), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdat(d_wdat), .d_gnt(d_gnt),
    .d_rdat(d_rdat), .d_rv(d_rv), .d_wv(d_wv), .d_err(d_err),
    .m_read_en(m_read_en), .m_read_addr(m_read_addr), .m_read_dat(m_read_dat),
    .m_r_v(m_r_v), .m_write_en(m_write_en), .m_write_addr(m_write_addr),
    .m_write_dat(m_write_dat), .m_w_v(m_w_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural memory: unwritten locations read back as addr*4.
  logic [DW-1:0] mem [logic [AW-1:0]];
  int mem_lat = 1;
  int mcnt = 0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a << 2;
  endfunction

  always @(negedge clk) begin
    if (!(m_read_en || m_write_en)) begin
      mcnt  = 0;
      m_r_v = 1'b0;
      m_w_v = 1'b0;
    end else begin
      mcnt++;
      if (mem_lat != 0 && mcnt == mem_lat) begin
        if (m_read_en) begin
          m_r_v      = 1'b1;
          m_read_dat = mem_rd(m_read_addr);
        end else begin
          m_w_v = 1'b1;
          mem[m_write_addr] = m_write_dat;
        end
      end else begin
        m_r_v = 1'b0;
        m_w_v = 1'b0;
      end
    end
  end

  typedef struct {
    logic [4:0]    pulse;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  // Pops one expected response for every response pulse seen.
  always @(negedge clk) begin
    logic [4:0] pv;
    exp_t e;
    pv = {i_rv, i_err, d_rv, d_wv, d_err};
    if (rst_n && pv != 5'b0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {59'b0, pv}, 64'b0);
      end else begin
        e = sbq.pop_front();
        chk("resp_kind", {59'b0, pv}, {59'b0, e.pulse});
        if (e.pulse == P_I_RV) chk("i_rdat", {32'b0, i_rdat}, {32'b0, e.data});
        if (e.pulse == P_D_RV) chk("d_rdat", {32'b0, d_rdat}, {32'b0, e.data});
      end
    end
  end

  typedef struct {
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    int            lat;
    bit            flush;
    logic [4:0]    exp_pulse;
    logic [DW-1:0] exp_data;
    int            exp_cyc;
  } vec_t;

  task automatic run_txn(input vec_t v);
    int cyc;
    logic [DW-1:0] old_irdat;
    exp_t e;
    mem_lat = v.lat;
    old_irdat = i_rdat;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdat = v.wdat;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    @(negedge clk);
    chk(v.is_d ? "d_gnt" : "i_gnt", {63'b0, v.is_d ? d_gnt : i_gnt}, 64'd1);
    chk("gnt_other", {63'b0, v.is_d ? i_gnt : d_gnt}, 64'd0);
    if (v.exp_pulse != 5'b0) begin
      e.pulse = v.exp_pulse;
      e.data  = v.exp_data;
      sbq.push_back(e);
    end
    cyc = 300;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      i_flush = (n == 1) && v.flush;
      @(negedge clk);
      if (n == 1) begin
        chk("m_read_en_c1",  {63'b0, m_read_en},  {63'b0, !(v.is_d && v.we)});
        chk("m_write_en_c1", {63'b0, m_write_en}, {63'b0, v.is_d && v.we});
        if (v.is_d && v.we) begin
          chk("m_write_addr", {32'b0, m_write_addr}, {32'b0, v.addr});
          chk("m_write_dat",  {32'b0, m_write_dat},  {32'b0, v.wdat});
        end else begin
          chk("m_read_addr", {32'b0, m_read_addr}, {32'b0, v.addr});
        end
      end
      if (!(m_read_en || m_write_en)) begin
        cyc = n;
        break;
      end
    end
    i_flush = 1'b0;
    chk("resp_cycle", 64'(cyc), 64'(v.exp_cyc));
    if (!v.is_d && v.exp_pulse == 5'b0) begin
      chk("i_rv_squashed", {63'b0, i_rv}, 64'd0);
      chk("i_rdat_kept", {32'b0, i_rdat}, {32'b0, old_irdat});
    end
  endtask

  vec_t vecs[$];
  string seq_exp;
  string seq_act;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdat = '0;
    m_read_dat = '0; m_r_v = 0; m_w_v = 0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {i_gnt, d_gnt, i_rv, i_err, d_rv, d_wv, d_err, m_read_en, m_write_en},
        64'd0);
    chk("rst_data", {i_rdat, d_rdat} | {m_read_addr, m_write_dat}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    vecs.push_back('{0, 0, 32'd8,   32'd0,   1, 0, P_I_RV,  32'd32,  2});
    vecs.push_back('{0, 0, 32'd8,   32'd0,   2, 0, P_I_RV,  32'd32,  3});
    vecs.push_back('{1, 1, 32'd256, 32'd257, 3, 0, P_D_WV,  32'd0,   4});
    vecs.push_back('{1, 0, 32'd256, 32'd0,   1, 0, P_D_RV,  32'd257, 2});
    vecs.push_back('{0, 0, 32'd4,   32'd0,   2, 1, 5'b0,    32'd0,   3});
    vecs.push_back('{0, 0, 32'd256, 32'd0,   1, 0, P_I_RV,  32'd257, 2});
    vecs.push_back('{1, 0, 32'h40,  32'd0,   0, 0, P_D_ERR, 32'd0,   TIMEOUT + 1});
    vecs.push_back('{1, 0, 32'h40,  32'd0,   1, 0, P_D_RV,  32'h100, 2});
    vecs.push_back('{0, 0, 32'h44,  32'd0,   0, 1, P_I_ERR, 32'd0,   TIMEOUT + 1});
    vecs.push_back('{1, 1, 32'h80,  32'hAB,  1, 0, P_D_WV,  32'd0,   2});
    foreach (vecs[k]) run_txn(vecs[k]);

    // Both ports request continuously: D,D,D,D,I repeated.
    mem_lat = 1;
    seq_exp = "DDDDIDDDDI";
    seq_act = "";
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h10;
    for (int n = 0; n < 400 && seq_act.len() < 10; n++) begin
      exp_t e;
      @(negedge clk);
      if (i_gnt || d_gnt) begin
        chk("gnt_excl", {63'b0, i_gnt && d_gnt}, 64'd0);
        seq_act = {seq_act, d_gnt ? "D" : "I"};
        e.pulse = d_gnt ? P_D_RV : P_I_RV;
        e.data  = d_gnt ? mem_rd(32'h10) : mem_rd(32'h20);
        sbq.push_back(e);
      end
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    repeat (5) @(negedge clk);
    chk("gnt_seq_len", 64'(seq_act.len()), 64'd10);
    for (int j = 0; j < 10; j++) begin
      if (j < seq_act.len()) chk("gnt_seq", 64'(seq_act[j]), 64'(seq_exp[j]));
    end

    // Reset in the middle of a data write that never completes.
    mem_lat = 0;
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h30; d_req = 1; d_we = 1; d_addr = 32'h90; d_wdat = 32'h55;
    @(negedge clk);
    chk("rst_seq_dgnt", {63'b0, d_gnt}, 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {i_gnt, d_gnt, i_rv, i_err, d_rv, d_wv, d_err, m_read_en, m_write_en},
        64'd0);
    chk("async_rst_data", {m_write_addr, m_write_dat}, 64'd0);
    chk("async_rst_rdat", {i_rdat, d_rdat}, 64'd0);
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("post_rst_pulses", {59'b0, i_rv, i_err, d_rv, d_wv, d_err}, 64'd0);
    end
    chk("post_rst_streak", 64'(dut.r_streak), 64'd0);
    chk("post_rst_idle", 64'(dut.r_state), 64'd0);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
